vector_response_checker: RTL



---
 rtl/vrc_pkg.sv | 21 ++
 rtl/vrc_sat_counter.sv | 23 ++
 rtl/vector_response_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vrc_pkg.sv
// vrc_pkg: shared types and constants for the vector response checker.
// Optional feature macro: VRC_XMASK_EN (per-vector don't-care mask).
package vrc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } vrc_state_t;

   // Default parameter values
   localparam int unsigned VRC_IN_W_DEF   = 1;
   localparam int unsigned VRC_OUT_W_DEF  = 1;
   localparam int unsigned VRC_SETTLE_DEF = 1;
   localparam int unsigned VRC_CNT_W_DEF  = 16;

   // "No error seen" marker for first_err_idx; sliced down to CNT_W by users
   localparam logic [63:0] VRC_NO_ERR = '1;

endpackage

// File: rtl/vrc_sat_counter.sv
// vrc_sat_counter: CNT_W-bit up-counter with synchronous clear that holds
// at its maximum value instead of wrapping.
module vrc_sat_counter
   import vrc_pkg::*;
#(
   parameter int unsigned CNT_W = VRC_CNT_W_DEF
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Clear on reset or clr; otherwise count up until all-ones, then hold
   always_ff @(posedge CK) begin
      if (!reset || clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/vector_response_checker.sv
// vector_response_checker: replays recorded (stimulus, expected) vector pairs
// onto a DUT, samples its response SETTLE cycles later and keeps mismatch
// statistics plus a final pass/fail.
// Optional feature macro: VRC_XMASK_EN adds a per-vector don't-care mask.
module vector_response_checker
   import vrc_pkg::*;
#(
   parameter int unsigned IN_W   = VRC_IN_W_DEF,
   parameter int unsigned OUT_W  = VRC_OUT_W_DEF,
   parameter int unsigned SETTLE = VRC_SETTLE_DEF,
   parameter int unsigned CNT_W  = VRC_CNT_W_DEF
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [IN_W-1:0]  vec_stim,
   input  logic [OUT_W-1:0] vec_exp,
`ifdef VRC_XMASK_EN
   input  logic [OUT_W-1:0] vec_mask,
`endif
   input  logic             vec_last,
   input  logic             restart,
   output logic [IN_W-1:0]  N,
   input  logic [OUT_W-1:0] dut_out,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] first_err_idx
);

   localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] NO_ERR = VRC_NO_ERR[CNT_W-1:0];

   vrc_state_t       state;
   logic [SW-1:0]    settle_cnt;
   logic [OUT_W-1:0] exp_q;
   logic             last_q;
   logic             mismatch;
   logic             sample;
   logic             clr;
`ifdef VRC_XMASK_EN
   logic [OUT_W-1:0] mask_q;
`endif

   assign sample = (state == ST_SAMPLE);
   assign clr    = (state == ST_DONE) && restart;

   // Compare the live DUT response against the latched golden value
   always_comb begin
`ifdef VRC_XMASK_EN
      mismatch = |((dut_out ^ exp_q) & ~mask_q);
`else
      mismatch = |(dut_out ^ exp_q);
`endif
   end

   // Run FSM: accept, settle, sample, and hold results in DONE
   always_ff @(posedge CK) begin
      if (!reset) begin
         state         <= ST_IDLE;
         N             <= '0;
         settle_cnt    <= '0;
         exp_q         <= '0;
         last_q        <= 1'b0;
         vec_ready     <= 1'b1;
         done          <= 1'b0;
         pass          <= 1'b0;
         first_err_idx <= NO_ERR;
`ifdef VRC_XMASK_EN
         mask_q        <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (vec_valid) begin
                  N          <= vec_stim;
                  exp_q      <= vec_exp;
                  last_q     <= vec_last;
`ifdef VRC_XMASK_EN
                  mask_q     <= vec_mask;
`endif
                  settle_cnt <= SW'(SETTLE);
                  vec_ready  <= 1'b0;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt <= SW'(1))
                  state <= ST_SAMPLE;
               else
                  settle_cnt <= settle_cnt - SW'(1);
            end
            ST_SAMPLE: begin
               // err_count is never zero once an error was seen (it saturates),
               // so it doubles as the "first error of this run" flag
               if (mismatch && (err_count == '0))
                  first_err_idx <= vec_count;
               if (last_q) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  state     <= ST_IDLE;
                  vec_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               if (restart) begin
                  state         <= ST_IDLE;
                  N             <= '0;
                  first_err_idx <= NO_ERR;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  vec_ready     <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   vrc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .CK    (CK),
      .reset (reset),
      .clr   (clr),
      .inc   (sample && mismatch),
      .count (err_count)
   );

   vrc_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
      .CK    (CK),
      .reset (reset),
      .clr   (clr),
      .inc   (sample),
      .count (vec_count)
   );

endmodule
